sdrc_wb_arbiter: RTL
====================

SDRC_WB_ARBITER -- requirements
Module: sdrc_wb_arbiter

Interface
REQ-001 The block SHALL have parameter APP_AW, default 26, meaning the Wishbone byte-address width.
REQ-002 The block SHALL have parameter dw, default 32, meaning the Wishbone data width; the select width is dw/8.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports m0_cyc_i / m1_cyc_i, input, 1 bit each: master bus cycle.
REQ-006 The block SHALL have ports m0_stb_i / m1_stb_i, input, 1 bit each: master strobe.
REQ-007 The block SHALL have ports m0_we_i / m1_we_i, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_addr_i / m1_addr_i, input, APP_AW bits each: address.
REQ-009 The block SHALL have ports m0_dat_i / m1_dat_i, input, dw bits each: write data.
REQ-010 The block SHALL have ports m0_sel_i / m1_sel_i, input, dw/8 bits each: byte enables.
REQ-011 The block SHALL have ports m0_cti_i / m1_cti_i, input, 3 bits each: cycle type.
REQ-012 The block SHALL have ports m0_ack_o / m1_ack_o, output, 1 bit each: per-master acknowledge.
REQ-013 The block SHALL have ports m0_dat_o / m1_dat_o, output, dw bits each: per-master read data.
REQ-014 The block SHALL have ports s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o and s_cti_o, all outputs, widths matching the master inputs; they form the slave-side request to the SDRAM controller Wishbone port.
REQ-015 The block SHALL have ports s_ack_i (input, 1 bit) and s_dat_i (input, dw bits): slave acknowledge and read data.
REQ-016 The block SHALL have port grant_o, output, 2 bits: one-hot current owner, 00 = none.

Function
REQ-017 FSM states: IDLE, OWN0, OWN1, TURN; the FSM is registered.
REQ-018 IDLE: if any mx_cyc_i is high, go to OWNx of the master chosen by the arbitration rule (REQ-027); otherwise stay in IDLE.
REQ-019 OWNx: stay while mx_cyc_i is high; when mx_cyc_i goes low, go to TURN.
REQ-020 TURN: lasts exactly one cycle with all s_* outputs low, then goes to IDLE; no same-cycle handover between masters.
REQ-021 In OWNx, s_* outputs SHALL be a combinational mux of master x's inputs; in IDLE and TURN, s_cyc_o, s_stb_o and s_we_o are 0, and s_addr_o, s_dat_o, s_sel_o and s_cti_o are 0.
REQ-022 mx_ack_o SHALL equal s_ack_i AND (state == OWNx); the non-owner ack is always 0.
REQ-023 mx_dat_o SHALL equal s_dat_i when in OWNx, else 0.
REQ-024 Grant latency: a request arriving in IDLE is forwarded on s_* in the cycle after it is sampled; the single-request arbitration overhead is 1 cycle.
REQ-025 An s_ack_i received in IDLE or TURN SHALL be discarded and not routed to any master.
REQ-026 A burst (cti 010) is never split; the grant holds until the owner's cyc drops.
REQ-027 Arbitration rule: selects between both masters when both request in IDLE in the same cycle; per REQ-036/037.
REQ-028 The owner's stb low with cyc high SHALL keep the grant (wait states are allowed).
REQ-029 grant_o SHALL be 01 in OWN0, 10 in OWN1, and 00 otherwise.

Reset
REQ-030 With wb_rst_i high at a clock edge, state SHALL become IDLE and the last-winner register SHALL become 1 (master 0 wins next).
REQ-031 During and after reset: all s_* outputs 0, mx_ack_o 0, mx_dat_o 0, grant_o 00.
REQ-032 Reset mid-transfer SHALL abort the grant immediately; no ack is routed in the reset cycle.

Configuration
REQ-033 The round-robin feature SHALL be controlled by macro SDRC_ARB_RR_EN.
REQ-034 When SDRC_ARB_RR_EN is defined, a 1-bit last-winner register SHALL update on each entry to OWNx.
REQ-035 When SDRC_ARB_RR_EN is not defined, the last-winner register SHALL be absent.
REQ-036 With SDRC_ARB_RR_EN defined, on simultaneous requests the master that did not win last SHALL be granted.
REQ-037 With SDRC_ARB_RR_EN not defined, master 0 SHALL always win simultaneous requests (fixed priority).

Verification
REQ-038 Single master: m0 reads addr 0x0000100, with s_ack_i 3 cycles after s_stb_o -> m0_ack_o pulses once, m0_dat_o = s_dat_i, and m1_ack_o stays 0.
REQ-039 Simultaneous requests with RR on: both masters hold cyc after reset -> m0 granted, TURN, then m1; the next simultaneous request -> m0.
REQ-040 Simultaneous requests with RR off: both masters request repeatedly 4 times -> m0 granted every time; m1 is granted only when m0 is idle.
REQ-041 Burst: m1 issues a 4-beat write (cti 010 x3, then 111) while m0 requests mid-burst -> all 4 acks go to m1, then one TURN cycle, then m0 is granted.
REQ-042 Reset mid-burst: assert wb_rst_i on beat 2 of an m0 read -> the next cycle shows grant_o 00 and s_cyc_o 0; a stray s_ack_i is not routed to any master.
REQ-043 Stray ack: s_ack_i = 1 during TURN -> m0_ack_o = m1_ack_o = 0.

Source files
------------

// File: rtl/sdrc_wb_arbiter.sv
// sdrc_wb_arbiter: two-master Wishbone arbiter in front of the SDRAM controller port.
// The owner's request is muxed combinationally onto s_*; after each ownership ends
// one idle TURN cycle separates masters.
// Optional round-robin tie-break is enabled by defining SDRC_ARB_RR_EN; without it,
// master 0 wins simultaneous requests (fixed priority).
//
// state | meaning
// IDLE  | no owner, s_* quiet, waiting for any cyc
// OWN0  | master 0 owns the slave port
// OWN1  | master 1 owns the slave port
// TURN  | one quiet cycle after an owner releases cyc
module sdrc_wb_arbiter #(
   parameter int APP_AW = 26,
   parameter int dw     = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,

   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [APP_AW-1:0] m0_addr_i,
   input  logic [dw-1:0]     m0_dat_i,
   input  logic [dw/8-1:0]   m0_sel_i,
   input  logic [2:0]        m0_cti_i,
   output logic              m0_ack_o,
   output logic [dw-1:0]     m0_dat_o,

   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [APP_AW-1:0] m1_addr_i,
   input  logic [dw-1:0]     m1_dat_i,
   input  logic [dw/8-1:0]   m1_sel_i,
   input  logic [2:0]        m1_cti_i,
   output logic              m1_ack_o,
   output logic [dw-1:0]     m1_dat_o,

   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [APP_AW-1:0] s_addr_o,
   output logic [dw-1:0]     s_dat_o,
   output logic [dw/8-1:0]   s_sel_o,
   output logic [2:0]        s_cti_o,
   input  logic              s_ack_i,
   input  logic [dw-1:0]     s_dat_i,

   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2,
      TURN = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   pick_m1;
   logic   own0;
   logic   own1;

`ifdef SDRC_ARB_RR_EN
   // last_q = 1 means master 1 won last, so master 0 gets the next tie
   logic last_q;

   // Record the winner on every entry to an OWN state
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         last_q <= 1'b1;
      else if (state_q == IDLE && state_d == OWN0)
         last_q <= 1'b0;
      else if (state_q == IDLE && state_d == OWN1)
         last_q <= 1'b1;
   end

   assign pick_m1 = m1_cyc_i & (~m0_cyc_i | ~last_q);
`else
   assign pick_m1 = m1_cyc_i & ~m0_cyc_i;
`endif

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; grant holds for the whole cyc, bursts included
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i || m1_cyc_i)
               state_d = pick_m1 ? OWN1 : OWN0;
         end
         OWN0: begin
            if (!m0_cyc_i)
               state_d = TURN;
         end
         OWN1: begin
            if (!m1_cyc_i)
               state_d = TURN;
         end
         TURN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reset masks ownership in the same cycle so a mid-transfer reset routes nothing
   assign own0 = (state_q == OWN0) && !wb_rst_i;
   assign own1 = (state_q == OWN1) && !wb_rst_i;

   // Slave-side request mux: owner's signals pass through, otherwise all zero
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_cti_o  = '0;
      if (own0) begin
         s_cyc_o  = m0_cyc_i;
         s_stb_o  = m0_stb_i;
         s_we_o   = m0_we_i;
         s_addr_o = m0_addr_i;
         s_dat_o  = m0_dat_i;
         s_sel_o  = m0_sel_i;
         s_cti_o  = m0_cti_i;
      end else if (own1) begin
         s_cyc_o  = m1_cyc_i;
         s_stb_o  = m1_stb_i;
         s_we_o   = m1_we_i;
         s_addr_o = m1_addr_i;
         s_dat_o  = m1_dat_i;
         s_sel_o  = m1_sel_i;
         s_cti_o  = m1_cti_i;
      end
   end

   assign m0_ack_o = s_ack_i & own0;
   assign m1_ack_o = s_ack_i & own1;
   assign m0_dat_o = own0 ? s_dat_i : '0;
   assign m1_dat_o = own1 ? s_dat_i : '0;
   assign grant_o  = {own1, own0};

endmodule
